// File: rtl/dpsram_w32_d512.sv
// ---------------------------------------------------------------------------
// dpsram_w32_d512 -- true dual-port synchronous RAM, one clock.
//
// Purpose:
//   DEPTH x DATA_W storage with two independent read/write ports (A and B).
//   Each port has a registered read path with one cycle of latency.
//
// Ports:
//   clk    in   1       single clock for both ports, rising edge
//   rst    in   1       asynchronous active-high reset (output registers only)
//   ena    in   1       port A enable
//   wea    in   1       port A write enable (qualified by ena)
//   addra  in   ADDR_W  port A address
//   dina   in   DATA_W  port A write data
//   douta  out  DATA_W  port A registered read data
//   enb    in   1       port B enable
//   web    in   1       port B write enable (qualified by enb)
//   addrb  in   ADDR_W  port B address
//   dinb   in   DATA_W  port B write data
//   doutb  out  DATA_W  port B registered read data
//
// Access protocol (both ports): there is no valid/ready handshake. A port
// performs exactly one access on every rising clk edge where its enable is 1
// and rst is 0; the access is a write when the write enable is also 1,
// otherwise a read. dout updates only on such edges and holds in between.
//
// Collision behaviour:
//   - same port read-during-write: write-first (dout shows the new din)
//   - cross port, one writes X, other reads X: reader sees old contents
//   - both ports write X at one edge: port A's data is stored
//
// There is no state machine in this block; behaviour is purely per-edge.
// ---------------------------------------------------------------------------
module dpsram_w32_d512 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb
);

  // Storage array. Deliberately has no reset: contents survive rst and are
  // undefined at power-up, so the array can map onto a block RAM.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_douta;
  logic [DATA_W-1:0] r_doutb;

  // Qualified write strobes. rst blocks writes so that any traffic presented
  // while the block is held in reset cannot disturb stored words.
  logic w_wr_a;
  logic w_wr_b;

  assign w_wr_a = ena & wea & ~rst;
  assign w_wr_b = enb & web & ~rst;

  // Array writes. Port B is written first and port A last in the same block,
  // so when both target one address the later assignment (port A) wins.
  always_ff @(posedge clk) begin
    if (w_wr_b) begin
      r_mem[addrb] <= dinb;
    end
    if (w_wr_a) begin
      r_mem[addra] <= dina;
    end
  end

  // Port A read register. On a write the incoming data is forwarded
  // (write-first); on a read the array is sampled before this edge's
  // writes land, which gives old data for a cross-port collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_douta <= '0;
    end else if (ena) begin
      r_douta <= wea ? dina : r_mem[addra];
    end
  end

  // Port B read register, same rules as port A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_doutb <= '0;
    end else if (enb) begin
      r_doutb <= web ? dinb : r_mem[addrb];
    end
  end

  assign douta = r_douta;
  assign doutb = r_doutb;

endmodule

// File: tb/tb_dpsram_w32_d512.sv
// ---------------------------------------------------------------------------
// tb_dpsram_w32_d512 -- self-checking bench for dpsram_w32_d512.
//
// Driver tasks apply one access per clock on the falling edge and push the
// expected read data of every enabled access into a per-port queue. A
// monitor notes which ports were enabled at each rising edge and compares
// dout one time unit later against the head of that port's queue.
// ---------------------------------------------------------------------------
module tb_dpsram_w32_d512;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              ena = 1'b0;
  logic              wea = 1'b0;
  logic [ADDR_W-1:0] addra = '0;
  logic [DATA_W-1:0] dina = '0;
  logic [DATA_W-1:0] douta;
  logic              enb = 1'b0;
  logic              web = 1'b0;
  logic [ADDR_W-1:0] addrb = '0;
  logic [DATA_W-1:0] dinb = '0;
  logic [DATA_W-1:0] doutb;

  dpsram_w32_d512 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_qa[$];
  logic [DATA_W-1:0] exp_qb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a port presents a result after every edge where it was enabled
  // outside reset.
  always @(posedge clk) begin
    logic sa;
    logic sb;
    logic [DATA_W-1:0] e;
    sa = ena && !rst;
    sb = enb && !rst;
    #1;
    if (sa) begin
      if (exp_qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL porta_unexpected: got %h expected none", douta);
      end else begin
        e = exp_qa.pop_front();
        check("porta_dout", douta, e);
      end
    end
    if (sb) begin
      if (exp_qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL portb_unexpected: got %h expected none", doutb);
      end else begin
        e = exp_qb.pop_front();
        check("portb_dout", doutb, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock of traffic on both ports. exp_x is pushed when that port is
  // enabled (for writes it is the write data, since reads are write-first).
  task automatic step(input logic a_en, input logic a_we,
                      input logic [ADDR_W-1:0] a_ad, input logic [DATA_W-1:0] a_di,
                      input logic [DATA_W-1:0] a_exp,
                      input logic b_en, input logic b_we,
                      input logic [ADDR_W-1:0] b_ad, input logic [DATA_W-1:0] b_di,
                      input logic [DATA_W-1:0] b_exp);
    @(negedge clk);
    ena = a_en; wea = a_we; addra = a_ad; dina = a_di;
    enb = b_en; web = b_we; addrb = b_ad; dinb = b_di;
    if (a_en && !rst) exp_qa.push_back(a_exp);
    if (b_en && !rst) exp_qb.push_back(b_exp);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Fill pattern: {7'b0, i+1, 7'b0, i} for 0..510, {23'b0, 511} for 511.
  function automatic logic [DATA_W-1:0] fill_word(input int i);
    logic [8:0] lo;
    logic [8:0] hi;
    lo = 9'(i);
    hi = 9'(i + 1);
    if (i == 511) return {23'b0, 9'd511};
    return {7'b0, hi, 7'b0, lo};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int budget;

    // Reset state, checked before any clock edge.
    #1;
    check("reset_douta", douta, 32'h0);
    check("reset_doutb", doutb, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill sweep through port A (write-first output also checked).
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 9'(i), fill_word(i), fill_word(i),
           1'b0, 1'b0, '0, '0, '0);
    end
    // Read back every word through port B.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, '0, '0,
           1'b1, 1'b0, 9'(i), '0, fill_word(i));
    end

    // Write-first on port A.
    step(1'b1, 1'b1, 9'd5, 32'hA5A5_0001, 32'hA5A5_0001,
         1'b0, 1'b0, '0, '0, '0);

    // Cross-port collision on addr 7: set old value, then A writes while B reads.
    step(1'b1, 1'b1, 9'd7, 32'h0000_0007, 32'h0000_0007,
         1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 9'd7, 32'h1111_1111, 32'h1111_1111,
         1'b1, 1'b0, 9'd7, '0, 32'h0000_0007);
    step(1'b0, 1'b0, '0, '0, '0,
         1'b1, 1'b0, 9'd7, '0, 32'h1111_1111);

    // Dual write to addr 3: each port sees its own data, A's data is stored.
    step(1'b1, 1'b1, 9'd3, 32'hAAAA_AAAA, 32'hAAAA_AAAA,
         1'b1, 1'b1, 9'd3, 32'hBBBB_BBBB, 32'hBBBB_BBBB);
    step(1'b1, 1'b0, 9'd3, '0, 32'hAAAA_AAAA,
         1'b1, 1'b0, 9'd3, '0, 32'hAAAA_AAAA);

    // Dual write to different addresses, read back crossed.
    step(1'b1, 1'b1, 9'd20, 32'h1234_5678, 32'h1234_5678,
         1'b1, 1'b1, 9'd21, 32'h8765_4321, 32'h8765_4321);
    step(1'b1, 1'b0, 9'd21, '0, 32'h8765_4321,
         1'b1, 1'b0, 9'd20, '0, 32'h1234_5678);

    // Boundary addresses read on both ports.
    step(1'b1, 1'b0, 9'd511, '0, 32'h0000_01FF,
         1'b1, 1'b0, 9'd0, '0, 32'h0001_0000);

    // Enable gating on port B: read 9, then a disabled write must do nothing.
    step(1'b0, 1'b0, '0, '0, '0,
         1'b1, 1'b0, 9'd9, '0, 32'h000A_0009);
    step(1'b0, 1'b0, '0, '0, '0,
         1'b0, 1'b1, 9'd9, 32'hDEAD_BEEF, '0);
    @(negedge clk);
    check("gated_doutb_hold", doutb, 32'h000A_0009);
    step(1'b0, 1'b0, '0, '0, '0,
         1'b1, 1'b0, 9'd9, '0, 32'h000A_0009);
    idle();

    // Mid-run asynchronous reset, checked before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_douta", douta, 32'h0);
    check("async_rst_doutb", doutb, 32'h0);
    // Writes and reads presented during reset are ignored.
    step(1'b1, 1'b1, 9'd5, 32'hDEAD_0005, '0,
         1'b1, 1'b1, 9'd9, 32'hDEAD_0009, '0);
    @(negedge clk);
    check("rst_hold_douta", douta, 32'h0);
    check("rst_hold_doutb", doutb, 32'h0);
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
    #2;
    rst = 1'b0;

    // Contents written before reset are retained, reset-time writes dropped.
    step(1'b1, 1'b0, 9'd5, '0, 32'hA5A5_0001,
         1'b1, 1'b0, 9'd9, '0, 32'h000A_0009);
    step(1'b1, 1'b0, 9'd7, '0, 32'h1111_1111,
         1'b1, 1'b0, 9'd3, '0, 32'hAAAA_AAAA);
    idle();
    idle();

    // Drain the scoreboard with a bounded wait.
    budget = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0",
               exp_qa.size(), exp_qb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpsram_w32_d512.md
DPSRAM_W32_D512 -- requirements
Module: dpsram_w32_d512

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 9, address width in bits.
REQ-003 Parameter DEPTH, default 512, number of words (2^ADDR_W).
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  single clock for both ports; all sampling on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ena  input  1  port A enable.
REQ-008 wea  input  1  port A write enable; effective only when ena=1.
REQ-009 addra  input  ADDR_W  port A address.
REQ-010 dina  input  DATA_W  port A write data.
REQ-011 douta  output  DATA_W  port A registered read data.
REQ-012 enb  input  1  port B enable.
REQ-013 web  input  1  port B write enable; effective only when enb=1.
REQ-014 addrb  input  ADDR_W  port B address.
REQ-015 dinb  input  DATA_W  port B write data.
REQ-016 doutb  output  DATA_W  port B registered read data.

Function
REQ-017 Storage SHALL be DEPTH words of DATA_W bits, accessible independently from both ports.
REQ-018 A write SHALL occur on a rising clk edge when en=1 and we=1 on that port: mem[addr] <= din.
REQ-019 Read latency SHALL be 1 cycle: with en=1 at edge N, dout SHALL show the word at addr after edge N and stay valid until the next enabled edge on that port.
REQ-020 With en=0, the port SHALL neither write nor update dout; dout holds its last value.
REQ-021 Same-port read-during-write SHALL be write-first: dout shows the newly written din after that edge.
REQ-022 Cross-port access, one port writing address X while the other reads X at the same edge, SHALL return the old contents of X on the reading port; the new value is visible from the next enabled read.
REQ-023 Both ports writing the same address at the same edge SHALL store port A's data (port A wins); each port's dout SHALL show its own din per REQ-021.
REQ-024 Both ports writing different addresses at the same edge SHALL perform both writes.
REQ-025 Address arithmetic: none; addresses are used directly; all 2^ADDR_W values are valid (0..511 by default).
REQ-026 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by rst; clients initialise contents by writing.
REQ-027 No internal state machine; behaviour SHALL be purely per-edge as above.

Reset
REQ-028 While rst=1, douta and doutb SHALL be 0 immediately, without waiting for clk, and SHALL ignore reads.
REQ-029 Writes presented while rst=1 SHALL be ignored.
REQ-030 Operation resumes at the first rising clk edge after rst deasserts; memory contents written before reset SHALL be retained.
REQ-031 Deasserting rst mid-sequence SHALL NOT corrupt any word not written during reset.

Verification
REQ-032 Fill sweep: port A writes mem[i]={7'b0,i+1,7'b0,i} for i=0..510, plus mem[511]={23'b0,9'd511}; port B then reads 0..511 -> doutb matches each word 1 cycle after its address.
REQ-033 Write-first: ena=wea=1, addra=5, dina=32'hA5A5_0001 -> douta=32'hA5A5_0001 after that edge.
REQ-034 Cross-port collision: A writes 32'h1111_1111 to addr 7 (old value 32'h0000_0007) while B reads addr 7 at the same edge -> doutb=32'h0000_0007; the next B read gives 32'h1111_1111.
REQ-035 Dual write, same address: A writes 32'hAAAA_AAAA and B writes 32'hBBBB_BBBB to addr 3 at one edge -> a later read of 3 returns 32'hAAAA_AAAA.
REQ-036 Enable gating: enb=0 with web=1, addrb=9, dinb=32'hDEAD_BEEF -> mem[9] unchanged and doutb holds.
REQ-037 Reset: assert rst mid-run -> douta=doutb=0 immediately, without waiting for clk; after release, a read of addr 5 returns 32'hA5A5_0001.
